// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes, default widths and the responder FSM states.
package axi_pkg;

  localparam int unsigned AXI_IDS_BITS  = 8;
  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_DATA_BITS = 32;
  localparam int unsigned AXI_LEN_BITS  = 4;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_default_slave_if.sv
// AXI4 slave-port bundle; the slave modport is the responder side, master the requester side.
interface axi_default_slave_if
  import axi_pkg::*;
#(
  parameter int unsigned ID_W   = AXI_IDS_BITS,
  parameter int unsigned ADDR_W = AXI_ADDR_BITS,
  parameter int unsigned DATA_W = AXI_DATA_BITS,
  parameter int unsigned LEN_W  = AXI_LEN_BITS
) ();

  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [LEN_W-1:0]    AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;

  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;

  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [LEN_W-1:0]    ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;

  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

endinterface

// File: rtl/axi_default_slave.sv
// Terminates unmapped AXI4 traffic: writes get a DECERR response, reads get ARLEN+1 zero DECERR beats.
module axi_default_slave
  import axi_pkg::*;
#(
  parameter int unsigned ID_W   = AXI_IDS_BITS,
  parameter int unsigned ADDR_W = AXI_ADDR_BITS,
  parameter int unsigned DATA_W = AXI_DATA_BITS,
  parameter int unsigned LEN_W  = AXI_LEN_BITS
) (
  input logic                clk,
  input logic                rst,
  axi_default_slave_if.slave s
);

  wr_state_e        w_state_q, w_state_d;
  rd_state_e        r_state_q, r_state_d;
  logic [ID_W-1:0]  bid_q, bid_d;
  logic [ID_W-1:0]  rid_q, rid_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             live_q;

  logic awready, arready, rvalid, rlast;
  logic aw_hs, ar_hs, r_hs;

  // Address/data/qualifier fields are never needed to answer with DECERR.
  logic unused_inputs;
  assign unused_inputs = ^{s.AWADDR, s.AWLEN, s.AWSIZE, s.AWBURST, s.WDATA, s.WSTRB,
                           s.ARADDR, s.ARSIZE, s.ARBURST};

  // live_q keeps the READYs low for the whole reset period even though the FSMs sit in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      bid_q     <= '0;
      rid_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      live_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bid_q     <= bid_d;
      rid_q     <= rid_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      live_q    <= 1'b1;
    end
  end

  assign awready = live_q && (w_state_q == W_IDLE);
  assign arready = live_q && (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_DATA);
  assign rlast   = rvalid && (cnt_q == len_q);

  assign aw_hs = s.AWVALID && awready;
  assign ar_hs = s.ARVALID && arready;
  assign r_hs  = rvalid && s.RREADY;

  // Write engine: terminates on WLAST only, burst length is not tracked.
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          bid_d     = s.AWID;
          w_state_d = W_DATA;
        end
      end
      W_DATA:  if (s.WVALID && s.WLAST) w_state_d = W_RESP;
      W_RESP:  if (s.BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read engine: counter stops at len_q, so it never wraps even for the longest burst.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rid_d     = s.ARID;
          len_d     = s.ARLEN;
          cnt_d     = '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (rlast) r_state_d = R_IDLE;
          else       cnt_d     = cnt_q + LEN_W'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign s.AWREADY = awready;
  assign s.WREADY  = (w_state_q == W_DATA);
  assign s.BVALID  = (w_state_q == W_RESP);
  assign s.BID     = bid_q;
  assign s.BRESP   = (w_state_q == W_RESP) ? DECERR : OKAY;

  assign s.ARREADY = arready;
  assign s.RVALID  = rvalid;
  assign s.RLAST   = rlast;
  assign s.RID     = rid_q;
  assign s.RDATA   = '0;
  assign s.RRESP   = rvalid ? DECERR : OKAY;

endmodule

// File: tb/tb_axi_default_slave.sv
// Directed self-checking bench for axi_default_slave.
module tb_axi_default_slave;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  axi_default_slave_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();

  axi_default_slave #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    n_checks++; if (bus.AWREADY !== 1'b0) begin n_fail++; $display("FAIL rst_awready got %b exp 0", bus.AWREADY); end
    n_checks++; if (bus.ARREADY !== 1'b0) begin n_fail++; $display("FAIL rst_arready got %b exp 0", bus.ARREADY); end
    n_checks++; if (bus.WREADY !== 1'b0) begin n_fail++; $display("FAIL rst_wready got %b exp 0", bus.WREADY); end
    n_checks++; if (bus.BVALID !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid got %b exp 0", bus.BVALID); end
    n_checks++; if (bus.RVALID !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %b exp 0", bus.RVALID); end
    n_checks++; if (bus.RLAST !== 1'b0) begin n_fail++; $display("FAIL rst_rlast got %b exp 0", bus.RLAST); end
    n_checks++; if ({bus.BID, bus.BRESP, bus.RID, bus.RDATA, bus.RRESP} !== 52'd0)
      begin n_fail++; $display("FAIL rst_payload got bid=%h bresp=%b rid=%h rdata=%h rresp=%b exp all 0",
                               bus.BID, bus.BRESP, bus.RID, bus.RDATA, bus.RRESP); end
    rst = 1'b0;
    cyc();
    n_checks++; if (bus.AWREADY !== 1'b1) begin n_fail++; $display("FAIL rel_awready got %b exp 1", bus.AWREADY); end
    n_checks++; if (bus.ARREADY !== 1'b1) begin n_fail++; $display("FAIL rel_arready got %b exp 1", bus.ARREADY); end
  endtask

  task automatic test_single_write();
    bus.AWID = 8'h15; bus.AWLEN = 4'd0; bus.AWADDR = 32'h4000_0000; bus.AWVALID = 1'b1;
    cyc();
    bus.AWVALID = 1'b0;
    n_checks++; if (bus.AWREADY !== 1'b0) begin n_fail++; $display("FAIL wr_awready_busy got %b exp 0", bus.AWREADY); end
    n_checks++; if (bus.WREADY !== 1'b1) begin n_fail++; $display("FAIL wr_wready got %b exp 1", bus.WREADY); end
    bus.WDATA = 32'hDEAD_BEEF; bus.WSTRB = 4'hF; bus.WLAST = 1'b1; bus.WVALID = 1'b1;
    cyc();
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    n_checks++; if (bus.BVALID !== 1'b1) begin n_fail++; $display("FAIL wr_bvalid got %b exp 1", bus.BVALID); end
    n_checks++; if (bus.BID !== 8'h15) begin n_fail++; $display("FAIL wr_bid got %h exp 15", bus.BID); end
    n_checks++; if (bus.BRESP !== 2'b11) begin n_fail++; $display("FAIL wr_bresp got %b exp 11", bus.BRESP); end
    n_checks++; if (bus.WREADY !== 1'b0) begin n_fail++; $display("FAIL wr_wready_resp got %b exp 0", bus.WREADY); end
    bus.BREADY = 1'b1;
    cyc();
    bus.BREADY = 1'b0;
    n_checks++; if (bus.BVALID !== 1'b0) begin n_fail++; $display("FAIL wr_bvalid_done got %b exp 0", bus.BVALID); end
    n_checks++; if (bus.AWREADY !== 1'b1) begin n_fail++; $display("FAIL wr_awready_back got %b exp 1", bus.AWREADY); end
  endtask

  task automatic test_read_burst();
    bus.ARID = 8'h2A; bus.ARLEN = 4'd3; bus.ARADDR = 32'h5000_0010; bus.ARVALID = 1'b1;
    cyc();
    bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.RVALID !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid beat=%0d got %b exp 1", i, bus.RVALID); end
      n_checks++; if (bus.RLAST !== (i == 3)) begin n_fail++; $display("FAIL rd_rlast beat=%0d got %b exp %b", i, bus.RLAST, (i == 3)); end
      n_checks++; if ({bus.RID, bus.RRESP, bus.RDATA} !== {8'h2A, 2'b11, 32'h0})
        begin n_fail++; $display("FAIL rd_payload beat=%0d got rid=%h rresp=%b rdata=%h exp 2a 11 0", i, bus.RID, bus.RRESP, bus.RDATA); end
      n_checks++; if (bus.ARREADY !== 1'b0) begin n_fail++; $display("FAIL rd_arready_busy beat=%0d got %b exp 0", i, bus.ARREADY); end
      cyc();
    end
    bus.RREADY = 1'b0;
    n_checks++; if (bus.RVALID !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_end got %b exp 0", bus.RVALID); end
    n_checks++; if (bus.ARREADY !== 1'b1) begin n_fail++; $display("FAIL rd_arready_back got %b exp 1", bus.ARREADY); end
  endtask

  task automatic test_backpressure();
    logic [4:0] pat;
    logic [4:0] exp_last;
    int beats;
    pat = 5'b10100;
    exp_last = 5'b11000;
    beats = 0;
    bus.ARID = 8'h5C; bus.ARLEN = 4'd1; bus.ARVALID = 1'b1;
    cyc();
    bus.ARVALID = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.RREADY = pat[k];
      n_checks++; if (bus.RVALID !== 1'b1) begin n_fail++; $display("FAIL bp_rvalid k=%0d got %b exp 1", k, bus.RVALID); end
      n_checks++; if (bus.RLAST !== exp_last[k]) begin n_fail++; $display("FAIL bp_rlast k=%0d got %b exp %b", k, bus.RLAST, exp_last[k]); end
      n_checks++; if ({bus.RID, bus.RRESP, bus.RDATA} !== {8'h5C, 2'b11, 32'h0})
        begin n_fail++; $display("FAIL bp_payload k=%0d got rid=%h rresp=%b rdata=%h exp 5c 11 0", k, bus.RID, bus.RRESP, bus.RDATA); end
      if (bus.RVALID === 1'b1 && bus.RREADY === 1'b1) beats++;
      cyc();
    end
    bus.RREADY = 1'b0;
    n_checks++; if (beats !== 2) begin n_fail++; $display("FAIL bp_beats got %0d exp 2", beats); end
    n_checks++; if (bus.RVALID !== 1'b0) begin n_fail++; $display("FAIL bp_rvalid_end got %b exp 0", bus.RVALID); end

    // W data offered before AW must wait; B is then held under BREADY low
    bus.WVALID = 1'b1; bus.WLAST = 1'b1; bus.WDATA = 32'h1234_5678;
    n_checks++; if (bus.WREADY !== 1'b0) begin n_fail++; $display("FAIL bp_wready_idle got %b exp 0", bus.WREADY); end
    cyc();
    n_checks++; if (bus.WREADY !== 1'b0) begin n_fail++; $display("FAIL bp_wready_wait got %b exp 0", bus.WREADY); end
    bus.AWID = 8'hA7; bus.AWVALID = 1'b1;
    cyc();
    bus.AWVALID = 1'b0;
    n_checks++; if (bus.WREADY !== 1'b1) begin n_fail++; $display("FAIL bp_wready_go got %b exp 1", bus.WREADY); end
    cyc();
    bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (bus.BVALID !== 1'b1) begin n_fail++; $display("FAIL bp_bvalid_hold k=%0d got %b exp 1", k, bus.BVALID); end
      n_checks++; if ({bus.BID, bus.BRESP} !== {8'hA7, 2'b11})
        begin n_fail++; $display("FAIL bp_b_stable k=%0d got bid=%h bresp=%b exp a7 11", k, bus.BID, bus.BRESP); end
      cyc();
    end
    bus.BREADY = 1'b1;
    cyc();
    bus.BREADY = 1'b0;
    n_checks++; if (bus.BVALID !== 1'b0) begin n_fail++; $display("FAIL bp_bvalid_done got %b exp 0", bus.BVALID); end
  endtask

  task automatic test_concurrency();
    int rbeats;
    rbeats = 0;
    bus.AWID = 8'h01; bus.AWLEN = 4'd2; bus.AWVALID = 1'b1;
    bus.ARID = 8'h02; bus.ARLEN = 4'd15; bus.ARVALID = 1'b1;
    n_checks++; if ({bus.AWREADY, bus.ARREADY} !== 2'b11)
      begin n_fail++; $display("FAIL cc_ready_both got %b%b exp 11", bus.AWREADY, bus.ARREADY); end
    cyc();
    bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
    n_checks++; if ({bus.AWREADY, bus.ARREADY, bus.WREADY, bus.RVALID} !== 4'b0011)
      begin n_fail++; $display("FAIL cc_accept got aw=%b ar=%b w=%b rv=%b exp 0 0 1 1", bus.AWREADY, bus.ARREADY, bus.WREADY, bus.RVALID); end
    bus.RREADY = 1'b1; bus.BREADY = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus.WVALID = (c < 3);
      bus.WLAST  = (c == 2);
      n_checks++; if (bus.RVALID !== 1'b1) begin n_fail++; $display("FAIL cc_rvalid c=%0d got %b exp 1", c, bus.RVALID); end
      n_checks++; if (bus.RLAST !== (c == 15)) begin n_fail++; $display("FAIL cc_rlast c=%0d got %b exp %b", c, bus.RLAST, (c == 15)); end
      n_checks++; if (bus.RID !== 8'h02) begin n_fail++; $display("FAIL cc_rid c=%0d got %h exp 02", c, bus.RID); end
      if (c < 3) begin
        n_checks++; if (bus.WREADY !== 1'b1) begin n_fail++; $display("FAIL cc_wready c=%0d got %b exp 1", c, bus.WREADY); end
      end
      if (c == 3) begin
        n_checks++; if ({bus.BVALID, bus.BID, bus.BRESP} !== {1'b1, 8'h01, 2'b11})
          begin n_fail++; $display("FAIL cc_b got bvalid=%b bid=%h bresp=%b exp 1 01 11", bus.BVALID, bus.BID, bus.BRESP); end
      end
      if (c == 4) begin
        n_checks++; if ({bus.BVALID, bus.AWREADY} !== 2'b01)
          begin n_fail++; $display("FAIL cc_b_done got bvalid=%b awready=%b exp 0 1", bus.BVALID, bus.AWREADY); end
      end
      if (bus.RVALID === 1'b1 && bus.RREADY === 1'b1) rbeats++;
      cyc();
    end
    bus.RREADY = 1'b0; bus.BREADY = 1'b0; bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    n_checks++; if (rbeats !== 16) begin n_fail++; $display("FAIL cc_rbeats got %0d exp 16", rbeats); end
    n_checks++; if ({bus.RVALID, bus.ARREADY} !== 2'b01)
      begin n_fail++; $display("FAIL cc_r_done got rvalid=%b arready=%b exp 0 1", bus.RVALID, bus.ARREADY); end
  endtask

  task automatic test_reset_mid_burst();
    int beats;
    beats = 0;
    bus.ARID = 8'h44; bus.ARLEN = 4'd7; bus.ARVALID = 1'b1;
    bus.AWID = 8'h66; bus.AWVALID = 1'b1;
    cyc();
    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
    bus.RREADY = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    n_checks++; if ({bus.RVALID, bus.RLAST, bus.RID, bus.WREADY, bus.AWREADY, bus.ARREADY} !== 13'd0)
      begin n_fail++; $display("FAIL mr_reset got rv=%b rl=%b rid=%h wr=%b awr=%b arr=%b exp all 0",
                               bus.RVALID, bus.RLAST, bus.RID, bus.WREADY, bus.AWREADY, bus.ARREADY); end
    rst = 1'b0;
    cyc();
    n_checks++; if ({bus.AWREADY, bus.ARREADY, bus.RVALID} !== 3'b110)
      begin n_fail++; $display("FAIL mr_idle got awr=%b arr=%b rv=%b exp 1 1 0", bus.AWREADY, bus.ARREADY, bus.RVALID); end
    bus.ARID = 8'h33; bus.ARLEN = 4'd0; bus.ARVALID = 1'b1;
    cyc();
    bus.ARVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (bus.RVALID === 1'b1) begin
        n_checks++; if ({bus.RLAST, bus.RID} !== {1'b1, 8'h33})
          begin n_fail++; $display("FAIL mr_single got rlast=%b rid=%h exp 1 33", bus.RLAST, bus.RID); end
        beats++;
      end
      cyc();
    end
    bus.RREADY = 1'b0;
    n_checks++; if (beats !== 1) begin n_fail++; $display("FAIL mr_beats got %0d exp 1", beats); end
  endtask

  initial begin
    rst = 1'b1;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = 3'd2; bus.AWBURST = 2'b01; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;

    test_reset();
    test_single_write();
    test_read_burst();
    test_backpressure();
    test_concurrency();
    test_reset_mid_burst();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
